pad_dir_sequencer: RTL

- Owns the output-enable and attribute inputs of NUM_PADS bidirectional pad cells in the pad ring.
- Applies direction/attribute change requests one at a time, with break-before-make turnaround: OE is held low for TURN_CYCLES cycles before it is raised again, so attributes settle while the pad is undriven.
- Rejects requests that would drive input-only pads.
- Sits between the pad-control register block and the pad ring.

---
 rtl/pad_dir_sequencer_pkg.sv | 21 ++
 rtl/pad_turn_counter.sv | 34 +++
 rtl/pad_dir_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pad_dir_sequencer_pkg.sv
// Shared types and helpers for the pad direction sequencer.
// Optional feature macro used elsewhere in this slice: PAD_SEQ_ERR_IRQ_EN.
package pad_dir_sequencer_pkg;

    // Sequencer states: wait for a request, hold OE low during turnaround, answer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESP  = 2'd2
    } pad_seq_state_e;

    // Width of the turnaround counter, able to hold 0..turn_cycles.
    function automatic int turn_cnt_width(input int turn_cycles);
        if (turn_cycles < 1) begin
            return 1;
        end else begin
            return $clog2(turn_cycles + 1);
        end
    endfunction

endpackage

// File: rtl/pad_turn_counter.sv
// Turnaround down-counter: loads TURN_CYCLES-1, decrements to zero and holds.
module pad_turn_counter
    import pad_dir_sequencer_pkg::*;
#(
    parameter int TURN_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNTW = turn_cnt_width(TURN_CYCLES);
    localparam logic [CNTW-1:0] LOAD_VAL = CNTW'(TURN_CYCLES - 1);

    logic [CNTW-1:0] cnt_r;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != {CNTW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNTW{1'b0}});

endmodule

// File: rtl/pad_dir_sequencer.sv
// Pad direction sequencer: applies one OE/attribute request at a time with a
// break-before-make turnaround, and rejects drives of input-only pads.
// Optional sticky error interrupt is built when PAD_SEQ_ERR_IRQ_EN is defined.
module pad_dir_sequencer
    import pad_dir_sequencer_pkg::*;
#(
    parameter int NUM_PADS = 8,
    parameter int PADATTR = 16,
    parameter int PADATTR_RND = (PADATTR == 0) ? 1 : PADATTR,
    parameter int TURN_CYCLES = 2,
    parameter logic [NUM_PADS-1:0] INPUT_ONLY_MASK = '0,
    parameter int IDXW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [IDXW-1:0]                 req_pad_idx_i,
    input  logic                            req_oe_i,
    input  logic [PADATTR_RND-1:0]          req_attr_i,
    output logic                            rsp_valid_o,
    output logic                            rsp_err_o,
    output logic                            busy_o,
    output logic [NUM_PADS-1:0]             pad_oe_o,
    output logic [NUM_PADS*PADATTR_RND-1:0] pad_attributes_o,
    input  logic                            err_clr_i,
    output logic                            err_irq_o
);

    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("pad_dir_sequencer: TURN_CYCLES must be >= 1");
    end

    localparam logic [IDXW:0] NUM_PADS_W = (IDXW + 1)'(NUM_PADS);

    pad_seq_state_e                 state_r;
    logic                           ready_r;
    logic                           busy_r;
    logic                           rsp_valid_r;
    logic                           rsp_err_r;
    logic [NUM_PADS-1:0]            pad_oe_r;
    logic [NUM_PADS*PADATTR_RND-1:0] pad_attr_r;
    logic [NUM_PADS-1:0]            sel_r;
    logic                           oe_r;

    logic [NUM_PADS-1:0] req_sel_s;
    logic                req_range_ok_s;
    logic                req_in_only_s;
    logic                req_cur_oe_s;
    logic                req_err_s;
    logic                req_direct_s;
    logic                accept_s;
    logic                cnt_load_s;
    logic                cnt_dec_s;
    logic                cnt_zero_s;

    // Decode the incoming request against the current pad state.
    always_comb begin
        req_sel_s = {NUM_PADS{1'b0}};
        for (int i = 0; i < NUM_PADS; i++) begin
            req_sel_s[i] = (req_pad_idx_i == IDXW'(i));
        end
        req_range_ok_s = ({1'b0, req_pad_idx_i} < NUM_PADS_W);
        req_in_only_s  = |(req_sel_s & INPUT_ONLY_MASK);
        req_cur_oe_s   = |(req_sel_s & pad_oe_r);
        req_err_s      = !req_range_ok_s || (req_oe_i && req_in_only_s);
        req_direct_s   = !req_cur_oe_s && !req_oe_i;
        accept_s       = req_valid_i && (state_r == IDLE);
        cnt_load_s     = accept_s && !req_err_s && !req_direct_s;
        cnt_dec_s      = (state_r == DRAIN) && !cnt_zero_s;
    end

    pad_turn_counter #(
        .TURN_CYCLES (TURN_CYCLES)
    ) u_turn_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (cnt_load_s),
        .dec    (cnt_dec_s),
        .zero   (cnt_zero_s)
    );

    // Sequencer FSM with registered pad, handshake and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            pad_oe_r    <= {NUM_PADS{1'b0}};
            pad_attr_r  <= {(NUM_PADS*PADATTR_RND){1'b0}};
            sel_r       <= {NUM_PADS{1'b0}};
            oe_r        <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        sel_r   <= req_sel_s;
                        oe_r    <= req_oe_i;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (req_err_s) begin
                            // Rejected: pads untouched, answer next cycle.
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            for (int i = 0; i < NUM_PADS; i++) begin
                                if (req_sel_s[i]) begin
                                    pad_attr_r[i*PADATTR_RND +: PADATTR_RND] <= req_attr_i;
                                end else begin
                                    pad_attr_r[i*PADATTR_RND +: PADATTR_RND] <=
                                        pad_attr_r[i*PADATTR_RND +: PADATTR_RND];
                                end
                            end
                            if (req_direct_s) begin
                                // Pad stays undriven: attributes change at once.
                                rsp_valid_r <= 1'b1;
                                state_r     <= RESP;
                            end else begin
                                // Break before make: release the pad first.
                                pad_oe_r <= pad_oe_r & ~req_sel_s;
                                state_r  <= DRAIN;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_zero_s) begin
                        pad_oe_r    <= (pad_oe_r & ~sel_r) | (sel_r & {NUM_PADS{oe_r}});
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PAD_SEQ_ERR_IRQ_EN
    logic err_irq_r;

    // Sticky error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_irq_r <= 1'b0;
        end else if (accept_s && req_err_s) begin
            err_irq_r <= 1'b1;
        end else if (err_clr_i) begin
            err_irq_r <= 1'b0;
        end else begin
            err_irq_r <= err_irq_r;
        end
    end

    assign err_irq_o = err_irq_r;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr_i;
    assign err_irq_o        = 1'b0;
`endif

    assign req_ready_o      = ready_r;
    assign busy_o           = busy_r;
    assign rsp_valid_o      = rsp_valid_r;
    assign rsp_err_o        = rsp_err_r;
    assign pad_oe_o         = pad_oe_r;
    assign pad_attributes_o = pad_attr_r;

endmodule
